// File: rtl/mem_wb_if.sv
// MEM-to-writeback result handshake. A result transfers on a posedge where
// in_valid and in_ready are both 1; in_valid/payload must hold while in_ready=0.
interface mem_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic        in_link;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc_plus4;

  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_link, in_rd,
           in_alu_result, in_mem_data, in_pc_plus4,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_link, in_rd,
           in_alu_result, in_mem_data, in_pc_plus4,
    output in_ready
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// Writeback stage: 2-entry result FIFO draining into the register file, with
// decode-stage busy/forwarding lookup over the queued (not yet issued) writes.
module mem_wb_writeback (
  input  logic        clk,
  input  logic        rst_n,
  mem_wb_if.slave     mem,
  input  logic        wb_hold,
  output logic        regwrite,
  output logic [4:0]  addr_write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  query_addr_1,
  input  logic [4:0]  query_addr_2,
  output logic        busy_1,
  output logic        busy_2,
  output logic [31:0] fwd_data_1,
  output logic [31:0] fwd_data_2,
  output logic [31:0] wb_count,
  output logic [1:0]  occupancy
);

  logic        we_q   [2];
  logic [4:0]  rd_q   [2];
  logic [31:0] data_q [2];

  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;

  logic        accept;
  logic        pop;
  logic        sel_we;
  logic [31:0] sel_data;

  logic        live [2];
  logic        young;
  logic        old;

  assign occupancy = count;
  assign mem.in_ready = rst_n && (count != 2'd2);
  assign accept = mem.in_valid && mem.in_ready;
  // Pop decision uses registered occupancy, so a fresh accept into an empty
  // queue always waits one edge before draining.
  assign pop = (count != 2'd0) && !wb_hold;

  always_comb begin
    sel_data = mem.in_alu_result;
    if (mem.in_link)
      sel_data = mem.in_pc_plus4;
    else if (mem.in_memtoreg)
      sel_data = mem.in_mem_data;
  end

  assign sel_we = mem.in_regwrite && (mem.in_rd != 5'd0);

  function automatic logic hit(input logic [4:0] q, input logic slot_live,
                               input logic slot_we, input logic [4:0] slot_rd);
    return slot_live && slot_we && (slot_rd == q) && (q != 5'd0);
  endfunction

  always_comb begin
    live[0] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b0));
    live[1] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b1));
    old     = rd_ptr;
    young   = (count == 2'd2) ? ~rd_ptr : rd_ptr;
  end

  // Youngest matching entry wins; the output register is excluded because the
  // register file will already hold its value by the time decode reads it.
  always_comb begin
    busy_1     = 1'b0;
    fwd_data_1 = 32'd0;
    busy_2     = 1'b0;
    fwd_data_2 = 32'd0;
    if (rst_n) begin
      if (hit(query_addr_1, live[young], we_q[young], rd_q[young])) begin
        busy_1     = 1'b1;
        fwd_data_1 = data_q[young];
      end else if (hit(query_addr_1, live[old], we_q[old], rd_q[old])) begin
        busy_1     = 1'b1;
        fwd_data_1 = data_q[old];
      end
      if (hit(query_addr_2, live[young], we_q[young], rd_q[young])) begin
        busy_2     = 1'b1;
        fwd_data_2 = data_q[young];
      end else if (hit(query_addr_2, live[old], we_q[old], rd_q[old])) begin
        busy_2     = 1'b1;
        fwd_data_2 = data_q[old];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q[wr_ptr]   <= sel_we;
      rd_q[wr_ptr]   <= mem.in_rd;
      data_q[wr_ptr] <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count          <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      regwrite       <= 1'b0;
      addr_write_reg <= 5'd0;
      write_data     <= 32'd0;
      wb_count       <= 32'd0;
    end else begin
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr         <= ~rd_ptr;
        regwrite       <= we_q[rd_ptr];
        addr_write_reg <= rd_q[rd_ptr];
        write_data     <= data_q[rd_ptr];
        if (we_q[rd_ptr])
          wb_count <= wb_count + 32'd1;
      end else begin
        regwrite <= 1'b0;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized + directed bench for mem_wb_writeback with a queue-based reference
// model and a negedge monitor scoring writes and lookups against it.
module tb_mem_wb_writeback;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        wb_hold;
  logic        regwrite;
  logic [4:0]  addr_write_reg;
  logic [31:0] write_data;
  logic [4:0]  query_addr_1, query_addr_2;
  logic        busy_1, busy_2;
  logic [31:0] fwd_data_1, fwd_data_2;
  logic [31:0] wb_count;
  logic [1:0]  occupancy;

  mem_wb_if bus ();

  mem_wb_writeback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem            (bus),
    .wb_hold        (wb_hold),
    .regwrite       (regwrite),
    .addr_write_reg (addr_write_reg),
    .write_data     (write_data),
    .query_addr_1   (query_addr_1),
    .query_addr_2   (query_addr_2),
    .busy_1         (busy_1),
    .busy_2         (busy_2),
    .fwd_data_1     (fwd_data_1),
    .fwd_data_2     (fwd_data_2),
    .wb_count       (wb_count),
    .occupancy      (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  ent_t        mq[$];
  logic [36:0] exp_q[$];
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_lookup(input logic [4:0] q);
    if (!rst_n || q == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].we && mq[i].rd == q) return {1'b1, mq[i].data};
    return 33'd0;
  endfunction

  // reference model: advances on every posedge from the inputs present there
  always @(posedge clk) begin
    ent_t e;
    bit   acc;
    if (!rst_n) begin
      mq.delete();
      m_cnt = 32'd0;
    end else begin
      acc = bus.in_valid && (mq.size() < 2);
      if (mq.size() > 0 && !wb_hold) begin
        e = mq.pop_front();
        if (e.we) begin
          exp_q.push_back({e.rd, e.data});
          m_cnt = m_cnt + 32'd1;
        end
      end
      if (acc) begin
        e.we   = bus.in_regwrite && (bus.in_rd != 5'd0);
        e.rd   = bus.in_rd;
        e.data = bus.in_link ? bus.in_pc_plus4 :
                 bus.in_memtoreg ? bus.in_mem_data : bus.in_alu_result;
        mq.push_back(e);
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [32:0] l1, l2;
    logic [36:0] w;
    if (mon_en) begin
      l1 = model_lookup(query_addr_1);
      l2 = model_lookup(query_addr_2);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rst_n && (mq.size() < 2)});
      chk("occupancy", {30'd0, occupancy}, mq.size());
      chk("busy_1", {31'd0, busy_1}, {31'd0, l1[32]});
      chk("fwd_data_1", fwd_data_1, l1[31:0]);
      chk("busy_2", {31'd0, busy_2}, {31'd0, l2[32]});
      chk("fwd_data_2", fwd_data_2, l2[31:0]);
      chk("wb_count", wb_count, m_cnt);
      if (regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rd=%0d data=%h expected no write at %0t",
                   addr_write_reg, write_data, $time);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", {27'd0, addr_write_reg}, {27'd0, w[36:32]});
          chk("write_data", write_data, w[31:0]);
        end
      end
    end
  end

  // driver
  task automatic step(input logic v, input logic rw, input logic mtr, input logic lnk,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] md,
                      input logic [31:0] pc, input logic hold);
    bus.in_valid      = v;
    bus.in_regwrite   = rw;
    bus.in_memtoreg   = mtr;
    bus.in_link       = lnk;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_mem_data   = md;
    bus.in_pc_plus4   = pc;
    wb_hold           = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_step(input int hold_pct);
    query_addr_1 = 5'($urandom_range(0, 7));
    query_addr_2 = 5'($urandom_range(0, 7));
    step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 80),
         1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 20),
         5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
         ($urandom_range(0, 99) < hold_pct));
  endtask

  initial begin
    rst_n = 1'b0;
    query_addr_1 = 5'd0;
    query_addr_2 = 5'd0;
    bus.in_valid = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    idle(2);
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_addr", {27'd0, addr_write_reg}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // single ALU write
    query_addr_1 = 5'd5;
    step(1, 1, 0, 0, 5, 32'h1234, 0, 0, 0);
    idle(3);
    chk("single_wb_count", wb_count, 32'd1);

    // select priority
    step(1, 1, 1, 1, 3, 32'h11, 32'h22, 32'h40, 0);
    step(1, 1, 1, 0, 4, 32'h11, 32'hBEEF, 32'h40, 0);
    idle(3);

    // rd=0 never writes
    query_addr_1 = 5'd0;
    step(1, 1, 0, 0, 0, 32'h55, 0, 0, 0);
    idle(3);
    chk("rd0_wb_count", wb_count, 32'd3);

    // hold with three results, then release
    step(1, 1, 0, 0, 1, 32'hA1, 0, 0, 1);
    step(1, 1, 0, 0, 2, 32'hA2, 0, 0, 1);
    chk("hold_full_ready", {31'd0, bus.in_ready}, 32'd0);
    step(1, 1, 0, 0, 3, 32'hA3, 0, 0, 1);
    idle(4);

    // two queued writes to the same register
    query_addr_1 = 5'd7;
    query_addr_2 = 5'd7;
    step(1, 1, 0, 0, 7, 32'h1, 0, 0, 1);
    step(1, 1, 0, 0, 7, 32'h2, 0, 0, 1);
    chk("dup_fwd_young", fwd_data_1, 32'h2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dup_fwd_after_pop", fwd_data_2, 32'h2);
    idle(3);

    // reset mid-drain
    step(1, 1, 0, 0, 9, 32'hC1, 0, 0, 1);
    step(1, 1, 0, 0, 10, 32'hC2, 0, 0, 1);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    chk("mid_rst_count", wb_count, 32'd0);
    idle(4);

    // randomized traffic with varying hold pressure, plus an occasional reset
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) rst_n = 1'b0;
      if (i == 1001) rst_n = 1'b1;
      random_step((i % 400) < 200 ? 25 : 60);
    end
    idle(10);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
MEM_WB_WRITEBACK -- requirements
Module: mem_wb_writeback

Interface
REQ-001 Parameters: none; the queue depth is fixed at 2 entries.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  MEM stage presents a result this cycle.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_regwrite  input  1  result targets a register.
REQ-007 in_memtoreg  input  1  select in_mem_data as the result.
REQ-008 in_link  input  1  select in_pc_plus4 as the result (jal/jalr).
REQ-009 in_rd  input  5  destination register number.
REQ-010 in_alu_result, in_mem_data, in_pc_plus4  input  32 each  candidate result values.
REQ-011 wb_hold  input  1  freeze draining to the register file.
REQ-012 regwrite  output  1  register-file write enable.
REQ-013 addr_write_reg  output  5  register-file write address.
REQ-014 write_data  output  32  register-file write data.
REQ-015 query_addr_1, query_addr_2  input  5 each  decode-stage source registers.
REQ-016 busy_1, busy_2  output  1 each  a queued write targets the queried register.
REQ-017 fwd_data_1, fwd_data_2  output  32 each  youngest queued value for the queried register.
REQ-018 wb_count  output  32  number of register writes issued.

Function
REQ-019 Result select at accept time SHALL be: in_link ? in_pc_plus4 : in_memtoreg ? in_mem_data : in_alu_result; link has priority.
REQ-020 An entry SHALL be write-enabled only if in_regwrite=1 and in_rd!=0; other entries are accepted, queued and drained, but never assert regwrite.
REQ-021 The queue SHALL be a 2-entry FIFO holding {we, rd, data}; accept occurs on a posedge with in_valid=1 and in_ready=1.
REQ-022 in_ready SHALL be 1 iff rst_n=1 and occupancy<2; it is combinational from the registered occupancy.
REQ-023 Pop SHALL occur on a posedge with occupancy>0 and wb_hold=0; accept and pop in the same cycle are both allowed and leave occupancy unchanged.
REQ-024 Accept into an empty queue SHALL NOT be popped in the same cycle; the minimum latency is accept edge N, pop edge N+1, regwrite high for the cycle after N+1.
REQ-025 On a pop edge, the outputs SHALL update as regwrite<=we, addr_write_reg<=rd, write_data<=data; on non-pop edges regwrite<=0 and the address and data hold.
REQ-026 Outputs SHALL be posedge-registered so they are stable before the register file's negedge write.
REQ-027 busy_k SHALL be 1 iff a queued write-enabled entry has rd==query_addr_k and query_addr_k!=0.
REQ-028 fwd_data_k SHALL equal the data of the youngest matching entry, and 0 when busy_k=0.
REQ-029 The output stage SHALL NOT contribute to busy, because the register file writes at negedge and is read late in the cycle.
REQ-030 wb_count SHALL increment on each pop with we=1 and wrap from 0xFFFFFFFF to 0.
REQ-031 wb_hold=1 SHALL freeze pops only; accepts continue until the queue is full.

Reset
REQ-032 On a posedge with rst_n=0, the block SHALL clear occupancy and pointers and set regwrite=0, addr_write_reg=0, write_data=0 and wb_count=0; queued entries are discarded, including any reset arriving mid-drain.
REQ-033 While rst_n=0, in_ready=0 and busy_1=busy_2=0.

Verification
REQ-034 Single ALU write, rd=5, alu=0x1234 -> busy_1=1 with fwd_data_1=0x1234 (query_addr_1=5) for one cycle, then regwrite=1, addr=5, data=0x1234 for one cycle, and wb_count=1.
REQ-035 Select priority: link=1, memtoreg=1, pc+4=0x40 -> write_data=0x40; link=0, memtoreg=1, mem=0xBEEF -> write_data=0xBEEF.
REQ-036 in_rd=0 with regwrite=1 -> entry accepted, regwrite stays 0, busy=0, wb_count unchanged.
REQ-037 wb_hold=1 with three back-to-back results -> first two accepted, in_ready=0 on the third; release hold -> writes issue in order, one per cycle.
REQ-038 Two queued writes to rd=7 (0x1 then 0x2) -> fwd_data=0x2 until the younger entry drains; after the first pop fwd_data=0x2 and busy=1.
REQ-039 rst_n=0 for one edge with 2 entries queued -> occupancy 0, regwrite=0, wb_count=0, and no write issued afterward.
